// File: rtl/irq_source_conditioner_pkg.sv
// Shared constants for the interrupt source conditioner and the interrupt controller.
package irq_pkg;

    localparam logic MODE_LEVEL    = 1'b0;
    localparam logic MODE_EDGE     = 1'b1;
    localparam int   N_SRC_DEFAULT = 4;
    // Width of the controller's one-hot acknowledge vector.
    localparam int   ACK_W         = N_SRC_DEFAULT;

endpackage

// File: rtl/irq_source_conditioner_if.sv
// Bus between the conditioner and the controller; master = controller/driver side,
// slave = conditioner side.
interface irq_source_conditioner_if #(
    parameter int N_SRC = irq_pkg::N_SRC_DEFAULT
);
    logic [N_SRC-1:0] irq_in;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] ack;
    logic [N_SRC-1:0] ovf_clr;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] overflow;

    modport master (
        output irq_in, mode, mask, ack, ovf_clr,
        input  req, pending, overflow
    );

    modport slave (
        input  irq_in, mode, mask, ack, ovf_clr,
        output req, pending, overflow
    );
endinterface

// File: rtl/irq_source_conditioner_sync_line.sv
// One source line: synchroniser chain, optional glitch filter (IRQ_COND_GLITCH_FILTER_EN),
// and the delayed copy used for rising-edge detection.
module irq_sync_line #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_i,
    output logic s_o,
    output logic rise_o
);

    if (SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_cfg
        $error("irq_sync_line: SYNC_STAGES must be >= 2 and FILTER_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_raw;
    logic                   s_filt;
    logic                   s_d_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
    end

    assign s_raw = sync_q[SYNC_STAGES-1];

`ifdef IRQ_COND_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // The counter tracks how long s has disagreed with the filtered value.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (s_raw != filt_q) begin
            if (cnt_q == CW'(FILTER_CYCLES - 1)) filt_d = s_raw;
            else                                 cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign s_filt = filt_q;
`else
    assign s_filt = s_raw;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) s_d_q <= 1'b0;
        else          s_d_q <= s_filt;
    end

    assign s_o    = s_filt;
    assign rise_o = s_filt & ~s_d_q;

endmodule

// File: rtl/irq_source_conditioner.sv
// Interrupt source conditioner: per-line sync, edge/level detect, pending latch, masking
// and overflow tracking. Glitch filter compiled in with IRQ_COND_GLITCH_FILTER_EN.
module irq_source_conditioner
    import irq_pkg::*;
#(
    parameter int N_SRC         = N_SRC_DEFAULT,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    irq_source_conditioner_if.slave   bus
);

    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] edge_q, edge_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] ovf_q,  ovf_d;

    for (genvar i = 0; i < N_SRC; i++) begin : g_line
        irq_sync_line #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .irq_i   (bus.irq_in[i]),
            .s_o     (s[i]),
            .rise_o  (rise[i])
        );
    end

    // A new edge beats a same-cycle ack; the edge latch is held clear in level mode so
    // a switch to edge mode starts from nothing pending.
    always_comb begin
        edge_d = '0;
        pend_d = '0;
        ovf_d  = ovf_q & ~bus.ovf_clr;
        for (int i = 0; i < N_SRC; i++) begin
            if (bus.mode[i] == MODE_EDGE) begin
                edge_d[i] = rise[i] | (edge_q[i] & ~bus.ack[i]);
                pend_d[i] = edge_d[i];
                if (rise[i] && edge_q[i] && !bus.ack[i]) ovf_d[i] = 1'b1;
            end else begin
                pend_d[i] = s[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            edge_q <= edge_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.pending  = pend_q;
    assign bus.req      = pend_q & bus.mask;
    assign bus.overflow = ovf_q;

endmodule

// File: doc/irq_source_conditioner.md
# irq_source_conditioner

Front-end stage for the interrupt controller. It takes raw, asynchronous interrupt source lines, synchronises them, detects edges or levels per line, and applies masking. Edge events are latched as pending until the controller acknowledges them. The `req` vector drives the controller's request input, and the controller's one-hot `ack` output feeds back here to clear the latched edge.

## Interface
- `N_SRC`, default 4: number of interrupt source lines.
- `SYNC_STAGES`, default 2, minimum 2: synchroniser flops per line.
- `FILTER_CYCLES`, default 4, minimum 1: stability window. Used only when the glitch filter is compiled in.
- `clk` input 1: single clock domain.
- `reset_n` input 1: asynchronous, active-low reset.
- `irq_in` input N_SRC: raw asynchronous source lines, active-high.
- `mode` input N_SRC: per line, 1 = edge-triggered, 0 = level-sensitive. Quasi-static.
- `mask` input N_SRC: per line, 1 = enabled, 0 = masked.
- `ack` input N_SRC: one-cycle acknowledge pulse from the interrupt controller, at most one bit set.
- `ovf_clr` input N_SRC: per-line clear for the `overflow` flag.
- `req` output N_SRC: conditioned request vector to the interrupt controller.
- `pending` output N_SRC: raw pending state before masking, for status readback.
- `overflow` output N_SRC: sticky flag, set when an edge is lost.

## Operation
- **Synchronisation.** Each `irq_in` bit passes through `SYNC_STAGES` flops, giving `s`. One further flop holds `s_d`. The rising-edge strobe is `rise = s & ~s_d`.
- **Edge mode (`mode=1`).**
  - `pending` sets on `rise` and clears on `ack` for that line.
  - If `rise` and `ack` occur in the same cycle, the new edge wins and `pending` stays 1.
- **Level mode (`mode=0`).**
  - `pending <= s` every cycle. `ack` has no effect; the source must deassert itself.
  - The edge latch is forced to 0 while in level mode. A `mode` change takes effect on the next clock edge and starts from that cleared state.
- **Masking.**
  - `req = pending & mask`, combinational from registers.
  - A masked line still latches `pending`. Unmasking it later presents the request immediately.
- **Overflow.**
  - Sets in edge mode when `rise` occurs while `pending=1` and no `ack` is present for that line in the same cycle.
  - Cleared by `ovf_clr`. If set and clear occur in the same cycle, set wins.
  - Stays at 0 in level mode.
- **Reset.** Every flop clears asynchronously: synchronisers, `s_d`, filter state, `pending=0`, `overflow=0`, and therefore `req=0`. A reset in the middle of an event discards it. After `reset_n` deasserts, a line that is still high counts as a fresh rising edge once synchronised, because `s_d` reset to 0.

## Timing
- Clock edges are counted from the first clock edge at which `irq_in` is sampled high.
- `s` rises after `SYNC_STAGES` edges, and `pending`/`req` rise at edge `SYNC_STAGES+1`. The default is 3 cycles in both modes.
- In edge mode, `ack` at edge k clears `pending` at edge k, so `req` is low in cycle k+1.
- A second edge separated from the first by fewer than 2 low samples of `s` may be merged; this is not treated as an error.
- The source must hold each level for at least 2 cycles to be reliably captured.

## Configuration
- **`IRQ_COND_GLITCH_FILTER_EN` defined:**
  - A per-line counter sits between `s` and the edge/level logic.
  - The filtered signal changes only after `s` has held a new value for `FILTER_CYCLES` consecutive cycles. A shorter pulse is dropped.
  - This adds `FILTER_CYCLES` to the latency, giving 7 cycles with defaults.
  - The counter resets to 0 and the filtered value resets to 0.
- **Macro undefined:** the filter is absent, `FILTER_CYCLES` is ignored, and the latency is `SYNC_STAGES+1`.

## Structure
- **Shared package `irq_pkg`:**
  - `MODE_LEVEL=1'b0` and `MODE_EDGE=1'b1`.
  - Default `N_SRC`.
  - The one-hot ack width constant, shared with the interrupt controller.
- **Sub-module `irq_sync_line`:** one instance per line, generated. Contains the synchroniser chain, the optional filter and `s_d`, and outputs `s` and `rise`. The top level holds the `pending`/`overflow` logic and masking.

## Test plan
- **Edge latch and ack.** `mode=4'hF`, `mask=4'hF`, pulse `irq_in[2]` high for 3 cycles. Expect `req=4'b0100` at edge 3. Then `ack=4'b0100` for one cycle; expect `req=0` on the next cycle.
- **Level follow.** `mode=0`, hold `irq_in[0]=1`. Expect `req[0]=1` from edge 3 onward with `ack` ignored. Drop `irq_in[0]`; expect `req[0]=0` 3 cycles later.
- **Mask.** Set `mask[1]=0` and pulse `irq_in[1]`. Expect `pending[1]=1` and `req[1]=0`. Set `mask[1]=1`; expect `req[1]=1` in the same cycle.
- **Overflow and ack collision.**
  - Two separated `irq_in[3]` pulses with no `ack` between them: `overflow[3]=1`.
  - `rise` coinciding with `ack[3]`: `pending[3]` stays 1 and `overflow[3]` stays 0.
  - `ovf_clr[3]` clears the flag.
- **Reset mid-event.** Assert `reset_n=0` while `pending=4'b1010`. Expect `req`, `pending` and `overflow` to be 0 immediately, without waiting for a clock. Release with `irq_in[1]` still high; expect `req[1]=1` 3 edges after release.
- **Filter (macro defined, `FILTER_CYCLES=4`).**
  - A 3-cycle pulse on `irq_in[0]`: no `req`.
  - A 6-cycle pulse: `req[0]=1` at edge 7.
